// File: rtl/sdram_pkg.sv
// Shared SDRAM monitor definitions: command codes, pin encodings,
// error codes and the init FSM state type.
package sdram_pkg;

   // Decoded command codes
   localparam logic [2:0] CMD_NOP          = 3'd0;
   localparam logic [2:0] CMD_ACTIVE       = 3'd1;
   localparam logic [2:0] CMD_READ         = 3'd2;
   localparam logic [2:0] CMD_WRITE        = 3'd3;
   localparam logic [2:0] CMD_PRECHARGE    = 3'd4;
   localparam logic [2:0] CMD_AUTO_REFRESH = 3'd5;
   localparam logic [2:0] CMD_LOAD_MODE    = 3'd6;
   localparam logic [2:0] CMD_BURST_TERM   = 3'd7;

   // Pin encodings as {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] PIN_NOP          = 4'b0111;
   localparam logic [3:0] PIN_ACTIVE       = 4'b0011;
   localparam logic [3:0] PIN_READ         = 4'b0101;
   localparam logic [3:0] PIN_WRITE        = 4'b0100;
   localparam logic [3:0] PIN_PRECHARGE    = 4'b0010;
   localparam logic [3:0] PIN_AUTO_REFRESH = 4'b0001;
   localparam logic [3:0] PIN_LOAD_MODE    = 4'b0000;
   localparam logic [3:0] PIN_BURST_TERM   = 4'b0110;

   // Protocol violation codes; lower value wins on a tie
   localparam logic [3:0] ERR_NONE          = 4'd0;
   localparam logic [3:0] ERR_EARLY_CMD     = 4'd1;
   localparam logic [3:0] ERR_BAD_INIT_SEQ  = 4'd2;
   localparam logic [3:0] ERR_TIMING        = 4'd3;
   localparam logic [3:0] ERR_REFRESH_LATE  = 4'd4;
   localparam logic [3:0] ERR_BANK_CLOSED   = 4'd5;
   localparam logic [3:0] ERR_BANK_OPEN     = 4'd6;
   localparam logic [3:0] ERR_REF_BANK_OPEN = 4'd7;
   localparam logic [3:0] ERR_CKE_LOW       = 4'd8;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_WAIT_PALL,
      ST_WAIT_REF1,
      ST_WAIT_REF2,
      ST_WAIT_LMR,
      ST_OPERATIONAL
   } state_t;

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational SDRAM pin-to-command decode.
module sdram_cmd_decode
   import sdram_pkg::*;
(
   input  logic       i_cs_n,
   input  logic       i_ras_n,
   input  logic       i_cas_n,
   input  logic       i_we_n,
   output logic [2:0] o_cmd
);

   // Map the four command pins onto a command code; deselect is NOP
   always_comb begin
      o_cmd = CMD_NOP;
      case ({i_cs_n, i_ras_n, i_cas_n, i_we_n})
         PIN_ACTIVE:       o_cmd = CMD_ACTIVE;
         PIN_READ:         o_cmd = CMD_READ;
         PIN_WRITE:        o_cmd = CMD_WRITE;
         PIN_PRECHARGE:    o_cmd = CMD_PRECHARGE;
         PIN_AUTO_REFRESH: o_cmd = CMD_AUTO_REFRESH;
         PIN_LOAD_MODE:    o_cmd = CMD_LOAD_MODE;
         PIN_BURST_TERM:   o_cmd = CMD_BURST_TERM;
         default:          o_cmd = CMD_NOP;
      endcase
   end

endmodule

// File: rtl/sdram_cmd_monitor.sv
// SDRAM command-bus protocol monitor: init sequence FSM, guard timing,
// refresh interval and CKE checks, first-error latch.
// Define SDRAM_MON_BANK_CHECK_EN to compile in per-bank open-row tracking.
module sdram_cmd_monitor
   import sdram_pkg::*;
#(
   parameter int INIT_WAIT_CYCLES   = 16000,
   parameter int T_RP_CYCLES        = 2,
   parameter int T_RFC_CYCLES       = 6,
   parameter int T_MRD_CYCLES       = 2,
   parameter int REFRESH_MAX_CYCLES = 1250
) (
   input  logic        clk,
   input  logic        reset_port,
   input  logic        ram_side_cs_n_port,
   input  logic        ram_side_ras_n_port,
   input  logic        ram_side_cas_n_port,
   input  logic        ram_side_wr_en_port,
   input  logic        ram_side_ck_en_port,
   input  logic [11:0] ram_side_addr_port,
   input  logic [1:0]  ram_side_bank_addr_port,
   output logic        init_done_port,
   output logic [11:0] mode_reg_port,
   output logic [15:0] refresh_count_port,
   output logic        cmd_valid_port,
   output logic [2:0]  cmd_code_port,
   output logic [3:0]  bank_open_port,
   output logic        error_port,
   output logic [3:0]  error_code_port
);

   localparam int GMAX0 = (T_RP_CYCLES > T_RFC_CYCLES) ? T_RP_CYCLES : T_RFC_CYCLES;
   localparam int GMAX  = (GMAX0 > T_MRD_CYCLES) ? GMAX0 : T_MRD_CYCLES;
   localparam int GW    = $clog2(GMAX + 1);
   localparam int IW    = $clog2(INIT_WAIT_CYCLES + 1);
   localparam int RW    = $clog2(REFRESH_MAX_CYCLES + 1);

   logic [2:0]    w_cmd;
   logic          w_non_nop;
   logic          w_expected;
   logic          w_in_init;
   logic          w_oper;
   logic [8:1]    w_viol;
   logic [3:0]    w_err_code;

   state_t        r_state;
   logic [IW-1:0] r_init_cnt;
   logic [GW-1:0] r_guard;
   logic [RW-1:0] r_ref_timer;

   sdram_cmd_decode u_decode (
      .i_cs_n  (ram_side_cs_n_port),
      .i_ras_n (ram_side_ras_n_port),
      .i_cas_n (ram_side_cas_n_port),
      .i_we_n  (ram_side_wr_en_port),
      .o_cmd   (w_cmd)
   );

   assign w_non_nop = (w_cmd != CMD_NOP);
   assign w_oper    = (r_state == ST_OPERATIONAL);
   assign w_in_init = (r_state != ST_POWERUP) && (r_state != ST_OPERATIONAL);

   // Which command the init sequence is waiting for in the current state
   always_comb begin
      w_expected = 1'b0;
      case (r_state)
         ST_WAIT_PALL:               w_expected = (w_cmd == CMD_PRECHARGE) && ram_side_addr_port[10];
         ST_WAIT_REF1, ST_WAIT_REF2: w_expected = (w_cmd == CMD_AUTO_REFRESH);
         ST_WAIT_LMR:                w_expected = (w_cmd == CMD_LOAD_MODE);
         default:                    w_expected = 1'b0;
      endcase
   end

`ifdef SDRAM_MON_BANK_CHECK_EN
   logic [3:0] r_bank_open;

   // Open-row flags: ACTIVE opens a bank, PRECHARGE closes one or all
   always_ff @(posedge clk) begin
      if (reset_port) begin
         r_bank_open <= '0;
      end else begin
         case (w_cmd)
            CMD_ACTIVE:    r_bank_open[ram_side_bank_addr_port] <= 1'b1;
            CMD_PRECHARGE: begin
               if (ram_side_addr_port[10]) r_bank_open <= '0;
               else                        r_bank_open[ram_side_bank_addr_port] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bank_open_port = r_bank_open;
`else
   logic [1:0] w_unused_bank;
   assign w_unused_bank  = ram_side_bank_addr_port;
   assign bank_open_port = '0;
`endif

   // Collect every violation present on the sampled command this cycle
   always_comb begin
      w_viol    = '0;
      w_viol[1] = (r_state == ST_POWERUP) && w_non_nop;
      w_viol[2] = w_in_init && w_non_nop && !w_expected;
      w_viol[3] = w_non_nop && (r_guard != '0);
      w_viol[4] = w_oper && (w_cmd != CMD_AUTO_REFRESH) &&
                  (r_ref_timer == RW'(REFRESH_MAX_CYCLES - 1));
`ifdef SDRAM_MON_BANK_CHECK_EN
      w_viol[5] = ((w_cmd == CMD_READ) || (w_cmd == CMD_WRITE)) &&
                  !r_bank_open[ram_side_bank_addr_port];
      w_viol[6] = (w_cmd == CMD_ACTIVE) && r_bank_open[ram_side_bank_addr_port];
      w_viol[7] = (w_cmd == CMD_AUTO_REFRESH) && (r_bank_open != '0);
`endif
      w_viol[8] = w_oper && !ram_side_ck_en_port;
   end

   // Lowest-numbered violation wins when several coincide
   always_comb begin
      w_err_code = ERR_NONE;
      for (int i = 8; i >= 1; i--)
         if (w_viol[i]) w_err_code = 4'(i);
   end

   // Init sequence FSM with power-up wait counter and mode register capture
   always_ff @(posedge clk) begin
      if (reset_port) begin
         r_state        <= ST_POWERUP;
         r_init_cnt     <= '0;
         init_done_port <= 1'b0;
         mode_reg_port  <= '0;
      end else begin
         case (r_state)
            ST_POWERUP: begin
               if (ram_side_ck_en_port) begin
                  if (r_init_cnt == IW'(INIT_WAIT_CYCLES - 1)) r_state <= ST_WAIT_PALL;
                  else                                          r_init_cnt <= r_init_cnt + IW'(1);
               end
            end
            ST_WAIT_PALL: if (w_expected) r_state <= ST_WAIT_REF1;
            ST_WAIT_REF1: if (w_expected) r_state <= ST_WAIT_REF2;
            ST_WAIT_REF2: if (w_expected) r_state <= ST_WAIT_LMR;
            ST_WAIT_LMR: begin
               if (w_expected) begin
                  r_state        <= ST_OPERATIONAL;
                  init_done_port <= 1'b1;
                  mode_reg_port  <= ram_side_addr_port;
               end
            end
            ST_OPERATIONAL: if (w_cmd == CMD_LOAD_MODE) mode_reg_port <= ram_side_addr_port;
            default: r_state <= ST_POWERUP;
         endcase
      end
   end

   // Shared guard countdown reloaded by PRECHARGE, AUTO_REFRESH and LOAD_MODE
   always_ff @(posedge clk) begin
      if (reset_port) begin
         r_guard <= '0;
      end else begin
         case (w_cmd)
            CMD_PRECHARGE:    r_guard <= GW'(T_RP_CYCLES - 1);
            CMD_AUTO_REFRESH: r_guard <= GW'(T_RFC_CYCLES - 1);
            CMD_LOAD_MODE:    r_guard <= GW'(T_MRD_CYCLES - 1);
            default: if (r_guard != '0) r_guard <= r_guard - GW'(1);
         endcase
      end
   end

   // Cycles since last refresh; only runs once operational, parks at the limit
   always_ff @(posedge clk) begin
      if (reset_port || !w_oper || (w_cmd == CMD_AUTO_REFRESH))
         r_ref_timer <= '0;
      else if (r_ref_timer != RW'(REFRESH_MAX_CYCLES - 1))
         r_ref_timer <= r_ref_timer + RW'(1);
   end

   // Command report pulse and saturating refresh tally
   always_ff @(posedge clk) begin
      if (reset_port) begin
         cmd_valid_port     <= 1'b0;
         cmd_code_port      <= CMD_NOP;
         refresh_count_port <= '0;
      end else begin
         cmd_valid_port <= w_non_nop;
         cmd_code_port  <= w_cmd;
         if ((w_cmd == CMD_AUTO_REFRESH) && (refresh_count_port != 16'hFFFF))
            refresh_count_port <= refresh_count_port + 16'd1;
      end
   end

   // Sticky first-error latch
   always_ff @(posedge clk) begin
      if (reset_port) begin
         error_port      <= 1'b0;
         error_code_port <= ERR_NONE;
      end else if (!error_port && (w_err_code != ERR_NONE)) begin
         error_port      <= 1'b1;
         error_code_port <= w_err_code;
      end
   end

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Self-checking bench for sdram_cmd_monitor: directed scenarios with literal
// expectations plus randomized traffic against a cycle-time reference model.
module tb_sdram_cmd_monitor;

   localparam int INIT = 20;
   localparam int TRP  = 2;
   localparam int TRFC = 6;
   localparam int TMRD = 2;
   localparam int RMAX = 50;

   // Command codes written out independently of the design package
   localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                          C_PRE = 3'd4, C_REF = 3'd5, C_LMR = 3'd6, C_BST = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, cke = 1'b1;
   logic [11:0] addr = '0;
   logic [1:0]  ba = '0;

   logic        init_done, cmd_valid, error;
   logic [11:0] mode_reg;
   logic [15:0] refresh_count;
   logic [2:0]  cmd_code;
   logic [3:0]  bank_open, error_code;

   sdram_cmd_monitor #(
      .INIT_WAIT_CYCLES   (INIT),
      .T_RP_CYCLES        (TRP),
      .T_RFC_CYCLES       (TRFC),
      .T_MRD_CYCLES       (TMRD),
      .REFRESH_MAX_CYCLES (RMAX)
   ) dut (
      .clk                     (clk),
      .reset_port              (rst),
      .ram_side_cs_n_port      (cs_n),
      .ram_side_ras_n_port     (ras_n),
      .ram_side_cas_n_port     (cas_n),
      .ram_side_wr_en_port     (we_n),
      .ram_side_ck_en_port     (cke),
      .ram_side_addr_port      (addr),
      .ram_side_bank_addr_port (ba),
      .init_done_port          (init_done),
      .mode_reg_port           (mode_reg),
      .refresh_count_port      (refresh_count),
      .cmd_valid_port          (cmd_valid),
      .cmd_code_port           (cmd_code),
      .bank_open_port          (bank_open),
      .error_port              (error),
      .error_code_port         (error_code)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Reference model: time-stamp based (absolute cycle numbers, not countdowns)
   int          m_cyc, m_init, m_stage, m_next_ok, m_last_ref;
   logic [3:0]  m_bank;
   logic        e_done, e_valid, e_err;
   logic [11:0] e_mode;
   logic [15:0] e_rcnt;
   logic [2:0]  e_code;
   logic [3:0]  e_bank, e_ecode;

   function automatic logic [2:0] dec(input logic [3:0] p);
      if (p[3]) return C_NOP;
      case (p[2:0])
         3'b011:  return C_ACT;
         3'b101:  return C_RD;
         3'b100:  return C_WR;
         3'b010:  return C_PRE;
         3'b001:  return C_REF;
         3'b000:  return C_LMR;
         3'b110:  return C_BST;
         default: return C_NOP;
      endcase
   endfunction

   function automatic logic [3:0] pins(input logic [2:0] c);
      case (c)
         C_ACT:   return 4'b0011;
         C_RD:    return 4'b0101;
         C_WR:    return 4'b0100;
         C_PRE:   return 4'b0010;
         C_REF:   return 4'b0001;
         C_LMR:   return 4'b0000;
         C_BST:   return 4'b0110;
         default: return 4'b0111;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      logic [2:0] c;
      logic [8:0] vb;
      bit         nn, exp_ok;
      int         v;
      c  = dec({cs_n, ras_n, cas_n, we_n});
      nn = (c != C_NOP);
      if (rst) begin
         m_cyc = 0; m_init = 0; m_stage = 0; m_next_ok = 0; m_last_ref = 0; m_bank = '0;
         e_done = 0; e_valid = 0; e_err = 0; e_mode = '0; e_rcnt = '0;
         e_code = '0; e_bank = '0; e_ecode = '0;
      end else begin
         exp_ok = (m_stage == 1 && c == C_PRE && addr[10]) ||
                  ((m_stage == 2 || m_stage == 3) && c == C_REF) ||
                  (m_stage == 4 && c == C_LMR);
         vb    = '0;
         vb[1] = (m_stage == 0) && nn;
         vb[2] = (m_stage >= 1 && m_stage <= 4) && nn && !exp_ok;
         vb[3] = nn && (m_cyc < m_next_ok);
         vb[4] = (m_stage == 5) && (c != C_REF) && (m_cyc - m_last_ref >= RMAX);
`ifdef SDRAM_MON_BANK_CHECK_EN
         vb[5] = (c == C_RD || c == C_WR) && !m_bank[ba];
         vb[6] = (c == C_ACT) && m_bank[ba];
         vb[7] = (c == C_REF) && (m_bank != 0);
         if (c == C_ACT) m_bank[ba] = 1'b1;
         if (c == C_PRE) begin
            if (addr[10]) m_bank = '0;
            else          m_bank[ba] = 1'b0;
         end
`endif
         vb[8] = (m_stage == 5) && !cke;
         v = 0;
         for (int i = 1; i <= 8; i++) if (vb[i] && v == 0) v = i;

         if (c == C_PRE) m_next_ok = m_cyc + TRP;
         if (c == C_REF) m_next_ok = m_cyc + TRFC;
         if (c == C_LMR) m_next_ok = m_cyc + TMRD;
         if (m_stage == 5 && c == C_REF) m_last_ref = m_cyc;

         if (m_stage == 0) begin
            if (cke) begin
               m_init++;
               if (m_init == INIT) m_stage = 1;
            end
         end else if (exp_ok) begin
            if (m_stage == 4) begin
               e_done     = 1'b1;
               m_last_ref = m_cyc;
            end
            m_stage++;
         end
         if (m_stage == 5 && c == C_LMR) e_mode = addr;

         if (c == C_REF && e_rcnt != 16'hFFFF) e_rcnt++;
         e_valid = nn;
         e_code  = c;
`ifdef SDRAM_MON_BANK_CHECK_EN
         e_bank = m_bank;
`else
         e_bank = '0;
`endif
         if (!e_err && v != 0) begin
            e_err   = 1'b1;
            e_ecode = 4'(v);
         end
         m_cyc++;
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("init_done",     {31'd0, init_done},     {31'd0, e_done});
         chk("mode_reg",      {20'd0, mode_reg},      {20'd0, e_mode});
         chk("refresh_count", {16'd0, refresh_count}, {16'd0, e_rcnt});
         chk("cmd_valid",     {31'd0, cmd_valid},     {31'd0, e_valid});
         chk("cmd_code",      {29'd0, cmd_code},      {29'd0, e_code});
         chk("bank_open",     {28'd0, bank_open},     {28'd0, e_bank});
         chk("error",         {31'd0, error},         {31'd0, e_err});
         chk("error_code",    {28'd0, error_code},    {28'd0, e_ecode});
      end
   end

   task automatic apply(input logic [2:0] c, input logic [11:0] a = '0, input logic [1:0] b = '0);
      {cs_n, ras_n, cas_n, we_n} = pins(c);
      addr = a;
      ba   = b;
      @(negedge clk);
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) apply(C_NOP);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      cke = 1'b1;
      apply(C_NOP);
      rst = 1'b0;
   endtask

   task automatic legal_init;
      do_reset;
      nops(INIT);
      apply(C_PRE, 12'h400);
      nops(TRP - 1);
      apply(C_REF);
      nops(TRFC - 1);
      apply(C_REF);
      nops(TRFC - 1);
      apply(C_LMR, 12'h022);
      nops(TMRD - 1);
   endtask

   initial begin
      @(negedge clk);
      do_reset;
      chk_en = 1'b1;

      // Legal init sequence
      legal_init;
      chk("legal_done",  {31'd0, init_done},     32'd1);
      chk("legal_mode",  {20'd0, mode_reg},      32'h022);
      chk("legal_rcnt",  {16'd0, refresh_count}, 32'd2);
      chk("legal_err",   {31'd0, error},         32'd0);

      // AUTO_REFRESH during the power-up wait
      do_reset;
      nops(5);
      apply(C_REF);
      chk("early_err",   {31'd0, error},      32'd1);
      chk("early_code",  {28'd0, error_code}, 32'd1);
      chk("early_cmd",   {29'd0, cmd_code},   32'd5);

      // LOAD_MODE where the first AUTO_REFRESH belongs
      do_reset;
      nops(INIT);
      apply(C_PRE, 12'h400);
      nops(1);
      apply(C_LMR, 12'h033);
      chk("badseq_code", {28'd0, error_code}, 32'd2);
      nops(3);
      chk("badseq_done", {31'd0, init_done},  32'd0);

      // Refresh-to-refresh spacing shorter than tRFC
      do_reset;
      nops(INIT);
      apply(C_PRE, 12'h400);
      nops(1);
      apply(C_REF);
      nops(2);
      apply(C_REF);
      chk("trfc_code",   {28'd0, error_code}, 32'd3);

      // Refresh starvation once operational
      legal_init;
      nops(RMAX - 2);
      chk("late_pre",    {31'd0, error},      32'd0);
      nops(1);
      chk("late_err",    {31'd0, error},      32'd1);
      chk("late_code",   {28'd0, error_code}, 32'd4);

      // READ to a bank that was never activated
      legal_init;
      apply(C_RD, 12'h000, 2'd2);
`ifdef SDRAM_MON_BANK_CHECK_EN
      chk("rd_closed",   {28'd0, error_code}, 32'd5);
`else
      chk("rd_closed",   {31'd0, error},      32'd0);
`endif

      // Reset while operational restarts the full wait
      legal_init;
      apply(C_ACT, 12'h123, 2'd1);
      rst = 1'b1;
      apply(C_NOP);
      rst = 1'b0;
      chk("rst_done",    {31'd0, init_done},     32'd0);
      chk("rst_mode",    {20'd0, mode_reg},      32'd0);
      chk("rst_rcnt",    {16'd0, refresh_count}, 32'd0);
      chk("rst_bank",    {28'd0, bank_open},     32'd0);
      chk("rst_ecode",   {28'd0, error_code},    32'd0);
      nops(9);
      apply(C_PRE, 12'h400);
      chk("rst_rewait",  {28'd0, error_code},    32'd1);
      chk("rst_nodone",  {31'd0, init_done},     32'd0);

      // Randomized traffic; the model checks every cycle
      for (int it = 0; it < 25; it++) begin
         do_reset;
         for (int k = 0; k < 160; k++) begin
            int          r;
            logic [2:0]  c;
            logic [11:0] a;
            logic [1:0]  b;
            cke = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            r   = $urandom_range(0, 99);
            a   = 12'($urandom);
            b   = 2'($urandom);
            c   = 3'($urandom_range(1, 7));
            if (m_stage == 0) begin
               if (r >= 3) c = C_NOP;
            end else if (r < 55) begin
               c = C_NOP;
            end else if (r < 85 && m_cyc >= m_next_ok) begin
               case (m_stage)
                  1:       begin c = C_PRE; a[10] = 1'b1; end
                  2, 3:    c = C_REF;
                  4:       c = C_LMR;
                  default: if (m_cyc - m_last_ref > 35) c = C_REF;
               endcase
            end
            if ($urandom_range(0, 19) == 0) begin
               {cs_n, ras_n, cas_n, we_n} = {1'b1, 3'($urandom)};
               addr = a;
               ba   = b;
               @(negedge clk);
            end else begin
               apply(c, a, b);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
